// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives a req/ack data memory, stalls the pipe while an
// access is outstanding, resolves branch/JAL/JR redirects and generates the flush.
//
//   state  | meaning
//   S_IDLE | no access outstanding; accepts a live load/store from EX/MEM
//   S_WAIT | dm_req held, waiting for dm_ack or the timeout to expire
module mem_stage_ctrl #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int FLUSH_LEN = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic          mem_re,
  input  logic          mem_we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          zr,
  input  logic          ne,
  input  logic          ov,
  input  logic          br,
  input  logic [2:0]    br_cond,
  input  logic          jal,
  input  logic          jr,
  input  logic [AW-1:0] br_target,
  input  logic [AW-1:0] jal_target,
  input  logic [AW-1:0] jr_target,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_ack,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          stall,
  output logic          branch,
  output logic [AW-1:0] branch_addr,
  output logic          flush,
  output logic          mem_err
);

  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_LEN);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          dm_req_q, dm_req_d;
  logic          dm_we_q, dm_we_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_vld_q, rdata_vld_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          mem_err_q, mem_err_d;

  logic          flush_c;
  logic          act;
  logic          stall_c;
  logic          cond_true;
  logic          branch_c;

  assign flush_c = (flush_cnt_q != '0);
  assign act     = valid_in & ~flush_c;

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = ~zr;
      3'b001:  cond_true = zr;
      3'b010:  cond_true = ~(zr | ne);
      3'b011:  cond_true = ne;
      3'b100:  cond_true = ~ne;
      3'b101:  cond_true = ne | zr;
      3'b110:  cond_true = ov;
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    mem_err_d   = mem_err_q;
    stall_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (act & (mem_re | mem_we)) begin
          stall_c    = 1'b1;
          state_d    = S_WAIT;
          dm_req_d   = 1'b1;
          dm_we_d    = mem_we;
          dm_addr_d  = addr;
          dm_wdata_d = wdata;
          tmo_cnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (dm_ack) begin
          state_d  = S_IDLE;
          dm_req_d = 1'b0;
          if (!dm_we_q) begin
            rdata_d     = dm_rdata;
            rdata_vld_d = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // this is the TIMEOUT-th unacknowledged cycle: abandon the access
          state_d   = S_IDLE;
          dm_req_d  = 1'b0;
          mem_err_d = 1'b1;
          if (!dm_we_q) begin
            rdata_d     = '0;
            rdata_vld_d = 1'b1;
          end
        end else begin
          stall_c   = 1'b1;
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a redirect sharing a slot with a memory access resolves when the access completes
  assign branch_c = act & ~stall_c & (jal | jr | (br & cond_true));

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush_c) begin
      flush_cnt_d = flush_cnt_q - FW'(1);
    end else if (branch_c) begin
      flush_cnt_d = FLUSH_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      flush_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_vld   = rdata_vld_q;
  assign flush       = flush_c;
  assign mem_err     = mem_err_q;
  assign stall       = rst_n & stall_c;
  assign branch      = rst_n & branch_c;
  assign branch_addr = jal ? jal_target : (jr ? jr_target : br_target);

endmodule
